instruction_fetch: RTL and testbench

- Front-end fetch stage that generates the PC stream, issues in-order reads to instruction memory and buffers the returned words in a small FIFO.
- Delivers {instruction, PC} to instruction_decode over a valid/ready handshake; it is the producer side of the decode stage's instruction input.
- Accepts a redirect (branch/jump target) from later stages. On redirect it flushes buffered words and discards in-flight responses.

---
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Generic FIFO with synchronous clear; head word is read combinationally from storage.
// Push and pop may coincide at any occupancy; the owner never pushes into a full FIFO without popping.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // When full, wr_ptr == rd_ptr: the popped head is read this cycle before being overwritten.
  always_ff @(posedge i_clk) begin
    if (push && !clr) ram[wr_ptr] <= push_dat;
  end

  assign head_dat = ram[rd_ptr];
endmodule

// Fetch front end: PC stream -> imem reads -> {inst,pc} FIFO -> decode; first o_valid 2 cycles after first request.
// Requests are credit-limited by FIFO occupancy plus reads in flight, so decode stalls hold the PC without dropping data.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  logic [31:0] pc;
  logic        run;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] out_after;
  logic [CW:0]   credit_sum;
  logic        grant;
  logic        push;
  logic        pop;
  logic [31:0] tag_pc;
  fetch_ent_t  push_ent;
  fetch_ent_t  head_ent;

  assign credit_sum  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign o_imem_req  = run && !i_redirect && (credit_sum < DEPTH[CW:0]);
  assign o_imem_addr = pc;
  assign grant       = o_imem_req && i_imem_gnt;
  assign out_after   = outstanding + CW'(grant) - CW'(i_imem_rvalid);

  assign push     = i_imem_rvalid && !i_redirect && (discard == '0);
  assign pop      = o_valid && i_ready && !i_redirect;
  assign push_ent = '{inst: i_imem_rdata, pc: tag_pc};

  // Tag queue pairs each response with its request address; its occupancy is the outstanding count.
  fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr      (1'b0),
    .push     (grant),
    .push_dat (pc),
    .pop      (i_imem_rvalid),
    .head_dat (tag_pc),
    .count    (outstanding)
  );

  fifo #(.WIDTH($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_inst_q (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr      (i_redirect),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc      <= RESET_PC;
      discard <= '0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (i_redirect) begin
        pc      <= i_redirect_pc & 32'hFFFF_FFFC;
        // Replaces any older discard: outstanding already counts those reads.
        discard <= out_after;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (i_imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  assign o_valid = (fifo_count != '0);
  assign o_inst  = o_valid ? head_ent.inst : NOP;
  assign o_pc    = o_valid ? head_ent.pc   : pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: memory model answers grants after a set latency with rdata = addr ^ 32'hA5A5_0000;
// expected PCs are queued by the stimulus and checked by an independent monitor on every pop.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] XORK   = 32'hA5A5_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int grant_cnt = 0;
  int cyc = 0;
  int lat = 1;
  int p_base = 0;
  int g_base = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_pc;
  logic [7:0]  pat;

  instruction_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_req"},   32'(o_imem_req), 32'd0);
    check({tag, "_addr"},  o_imem_addr, RST_PC);
    check({tag, "_vld"},   32'(o_valid), 32'd0);
    check({tag, "_inst"},  o_inst, NOP);
    check({tag, "_pc"},    o_pc, RST_PC);
  endtask

  // Returns 3 time units after the negedge on which reset is released.
  task automatic do_reset(input logic g, input logic r, input int l);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_imem_gnt = g;
    i_ready = r;
    lat = l;
    exp_q.delete();
    #3;
    check_rst_outputs("in_rst");
    tick(2);
    i_rst = 1'b0;
    g_base = grant_cnt;
    p_base = pop_cnt;
    #3;
    check("rel_req", 32'(o_imem_req), 32'd0);
  endtask

  // Memory model: in-order responses, each one lat cycles after its grant.
  always begin
    @(negedge i_clk);
    cyc++;
    #1;
    if (i_rst) begin
      pend_addr.delete();
      pend_due.delete();
      i_imem_rvalid = 1'b0;
      i_imem_rdata = '0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata = pend_addr[0] ^ XORK;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        i_imem_rvalid = 1'b0;
      end
      if (o_imem_req && i_imem_gnt) begin
        pend_addr.push_back(o_imem_addr);
        pend_due.push_back(cyc + lat);
        grant_cnt++;
      end
    end
  end

  // Monitor: every pop must match the next expected PC and its instruction word.
  always begin
    @(negedge i_clk);
    #2;
    if (!i_rst && o_valid && i_ready && !i_redirect) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop actual_pc=%h required=none", o_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        check("pop_pc", o_pc, exp_pc);
        check("pop_inst", o_inst, exp_pc ^ XORK);
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_imem_gnt = 1'b0;
    i_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    pat = 8'b1001_0110;

    // Streaming at zero wait: one instruction per cycle after 2-cycle startup.
    do_reset(1'b1, 1'b1, 1);
    push_exp(32'h0, 64);
    tick(1); #3;
    check("p1_req", 32'(o_imem_req), 32'd1);
    check("p1_addr", o_imem_addr, 32'h0);
    tick(2); #3;
    check("p1_first_vld", 32'(o_valid), 32'd1);
    check("p1_first_pc", o_pc, 32'h0);
    check("p1_first_inst", o_inst, 32'hA5A5_0000);
    tick(19); #3;
    check("p1_pops", 32'(pop_cnt - p_base), 32'd20);

    // Decode stalled: exactly DEPTH grants, then drain in order and resume at 16.
    do_reset(1'b1, 1'b0, 1);
    push_exp(32'h0, 32);
    tick(10);
    i_ready = 1'b1;
    #3;
    check("p2_grants", 32'(grant_cnt - g_base), 32'd4);
    check("p2_req_full", 32'(o_imem_req), 32'd0);
    check("p2_addr_hold", o_imem_addr, 32'd16);
    check("p2_vld", 32'(o_valid), 32'd1);
    check("p2_head_pc", o_pc, 32'h0);
    tick(1); #3;
    check("p2_resume_req", 32'(o_imem_req), 32'd1);
    check("p2_resume_addr", o_imem_addr, 32'd16);
    tick(10); #3;
    check("p2_pops", 32'(pop_cnt - p_base), 32'd12);

    // Irregular decode readiness at high occupancy: order preserved, nothing lost.
    do_reset(1'b1, 1'b0, 2);
    push_exp(32'h0, 64);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      i_ready = pat[i[2:0]];
    end
    tick(1);
    i_ready = 1'b0;
    tick(8); #3;
    check("p3_full_vld", 32'(o_valid), 32'd1);
    check("p3_full_req", 32'(o_imem_req), 32'd0);
    check("p3_exp_left", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) check("p3_full_head", o_pc, exp_q[0]);
    tick(1);
    i_ready = 1'b1;
    tick(10); #3;
    check("p3_pops_min", 32'((pop_cnt - p_base) >= 8), 32'd1);

    // Redirect with 3 reads in flight: stale data dropped, fetch restarts at aligned target.
    do_reset(1'b1, 1'b1, 3);
    tick(4);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    exp_q.delete();
    #3;
    check("p4_redir_req", 32'(o_imem_req), 32'd0);
    check("p4_inflight", 32'(grant_cnt - g_base), 32'd3);
    tick(1);
    i_redirect = 1'b0;
    push_exp(32'h100, 32);
    #3;
    check("p4_new_req", 32'(o_imem_req), 32'd1);
    check("p4_new_addr", o_imem_addr, 32'h100);
    tick(3); #3;
    check("p4_stale_dropped", 32'(o_valid), 32'd0);
    tick(1); #3;
    check("p4_first_vld", 32'(o_valid), 32'd1);
    check("p4_first_pc", o_pc, 32'h100);
    check("p4_first_inst", o_inst, 32'hA5A5_0100);

    // Back-to-back redirects: the second target wins.
    tick(3);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    exp_q.delete();
    tick(1);
    i_redirect_pc = 32'h0000_0302;
    exp_q.delete();
    tick(1);
    i_redirect = 1'b0;
    g_base = pop_cnt;
    push_exp(32'h300, 32);
    #3;
    check("p4b_req", 32'(o_imem_req), 32'd1);
    check("p4b_addr", o_imem_addr, 32'h300);
    tick(12); #3;
    check("p4b_popped", 32'((pop_cnt - g_base) > 0), 32'd1);

    // Grant withheld: request and address hold, then a single PC increment.
    do_reset(1'b0, 1'b1, 1);
    push_exp(32'h0, 32);
    for (int i = 1; i <= 5; i++) begin
      tick(1); #3;
      check("p5_req_wait", 32'(o_imem_req), 32'd1);
      check("p5_addr_wait", o_imem_addr, 32'h0);
    end
    tick(1);
    i_imem_gnt = 1'b1;
    #3;
    check("p5_addr_at_gnt", o_imem_addr, 32'h0);
    tick(1); #3;
    check("p5_addr_step", o_imem_addr, 32'h4);
    tick(10); #3;
    check("p5_pops", 32'(pop_cnt - p_base), 32'd10);

    // Asynchronous reset mid-stream with 2 buffered and 2 outstanding.
    do_reset(1'b1, 1'b0, 3);
    push_exp(32'h0, 32);
    tick(6); #3;
    check("p6_pre_vld", 32'(o_valid), 32'd1);
    check("p6_pre_pc", o_pc, 32'h0);
    check("p6_pre_grants", 32'(grant_cnt - g_base), 32'd4);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check_rst_outputs("async_rst");
    tick(2);
    i_rst = 1'b0;
    i_ready = 1'b1;
    lat = 1;
    p_base = pop_cnt;
    push_exp(32'h0, 32);
    tick(1); #3;
    check("p6_restart_req", 32'(o_imem_req), 32'd1);
    check("p6_restart_addr", o_imem_addr, RST_PC);
    tick(11); #3;
    check("p6_pops", 32'(pop_cnt - p_base), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
